// File: rtl/control_pkg.sv
// Shared encodings for the multicycle controller: states, instruction fields,
// ALU operation codes and datapath mux select values.
package control_pkg;

    // Controller states; the numeric values are visible on state_o.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    // instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field, instr[24:21]
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    // alu_control_o
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // alu_src_b_o
    localparam logic [1:0] SRC_B_RM   = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // result_src_o
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // True in the two states where the ALU performs the decoded operation.
    function automatic logic is_exec_state(state_e st);
        return (st == StExecR) || (st == StExecI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the data-processing cmd and S bit to the ALU operation,
// the flag-write requests and whether the result write-back is suppressed.
module alu_decoder
    import control_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    input  logic       exec,
    output logic [1:0] alu_control,
    output logic [1:0] flag_write,
    output logic       suppress_write
);

    logic [1:0] op;
    logic       set_nz;
    logic       arith;

    // Decode cmd; CMP behaves as SUBS without a write, unknown cmds do nothing.
    always_comb begin
        op             = ALU_ADD;
        set_nz         = 1'b0;
        arith          = 1'b0;
        suppress_write = 1'b1;
        case (cmd)
            CMD_ADD: begin
                op             = ALU_ADD;
                set_nz         = s;
                arith          = 1'b1;
                suppress_write = 1'b0;
            end
            CMD_SUB: begin
                op             = ALU_SUB;
                set_nz         = s;
                arith          = 1'b1;
                suppress_write = 1'b0;
            end
            CMD_AND: begin
                op             = ALU_AND;
                set_nz         = s;
                suppress_write = 1'b0;
            end
            CMD_ORR: begin
                op             = ALU_ORR;
                set_nz         = s;
                suppress_write = 1'b0;
            end
            CMD_CMP: begin
                op             = ALU_SUB;
                set_nz         = 1'b1;
                arith          = 1'b1;
            end
            default: begin
                op             = ALU_ADD;
                set_nz         = 1'b0;
                arith          = 1'b0;
                suppress_write = 1'b1;
            end
        endcase
    end

    // Outside execute the ALU is used for PC/address arithmetic: plain ADD, no flags.
    always_comb begin
        alu_control = ALU_ADD;
        flag_write  = 2'b00;
        if (exec) begin
            alu_control = op;
            flag_write  = {set_nz, set_nz & arith};
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main controller: sequences fetch/decode/execute/writeback and
// drives the datapath selects plus the unconditioned write/PC requests.
module control_fsm
    import control_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] op_i,
    input  logic [5:0] funct_i,
    input  logic [3:0] rd_i,
    input  logic       mem_ready_i,
    output logic       ir_write_o,
    output logic       next_pc_o,
    output logic       adr_src_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_control_o,
    output logic [1:0] flag_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       pcs_o,
    output logic [3:0] state_o
);

    state_e state_q;
    logic   suppress_write;
    logic   fetch_done;

    alu_decoder u_alu_decoder (
        .cmd            (funct_i[4:1]),
        .s              (funct_i[0]),
        .exec           (is_exec_state(state_q)),
        .alu_control    (alu_control_o),
        .flag_write     (flag_write_o),
        .suppress_write (suppress_write)
    );

    // State register and transitions; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:    if (mem_ready_i) state_q <= StDecode;
                StDecode: begin
                    case (op_i)
                        OP_MEM:  state_q <= StMemAdr;
                        OP_DP:   state_q <= funct_i[5] ? StExecI : StExecR;
                        OP_BR:   state_q <= StBranch;
                        default: state_q <= StFetch;
                    endcase
                end
                StMemAdr:   state_q <= funct_i[0] ? StMemRead : StMemWrite;
                StMemRead:  if (mem_ready_i) state_q <= StMemWb;
                StMemWrite: if (mem_ready_i) state_q <= StFetch;
                StExecR,
                StExecI:    state_q <= StAluWb;
                default:    state_q <= StFetch;
            endcase
        end
    end

    // Fetch completion is gated by reset so nothing loads while reset is held.
    assign fetch_done = mem_ready_i & rst_i;

    // Moore output decode; only the fetch handshake looks at mem_ready_i.
    always_comb begin
        ir_write_o   = 1'b0;
        next_pc_o    = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRC_B_RM;
        result_src_o = RES_ALUOUT;
        reg_write_o  = 1'b0;
        mem_write_o  = 1'b0;
        pcs_o        = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_o   = fetch_done;
                next_pc_o    = fetch_done;
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
            end
            StDecode: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o  = SRC_B_FOUR;
                result_src_o = RES_ALU;
            end
            StMemAdr:   alu_src_b_o = SRC_B_IMM;
            StMemRead:  adr_src_o = 1'b1;
            StMemWb: begin
                result_src_o = RES_RDATA;
                reg_write_o  = 1'b1;
            end
            StMemWrite: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            StExecR:    alu_src_b_o = SRC_B_RM;
            StExecI:    alu_src_b_o = SRC_B_IMM;
            StAluWb:    reg_write_o = ~suppress_write;
            StBranch: begin
                alu_src_b_o  = SRC_B_IMM;
                result_src_o = RES_ALU;
                pcs_o        = 1'b1;
            end
            default: ;
        endcase
        // A register write to R15 redirects the PC.
        if ((state_q == StMemWb || state_q == StAluWb) && reg_write_o && rd_i == 4'd15) begin
            pcs_o = 1'b1;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized scoreboard bench for control_fsm: the driver expands each
// instruction into its expected per-cycle state trace and output record,
// and a monitor compares every cycle at the falling edge.
module tb_control_fsm;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] op_i;
    logic [5:0] funct_i;
    logic [3:0] rd_i;
    logic       mem_ready_i;
    logic       ir_write_o, next_pc_o, adr_src_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, result_src_o, alu_control_o, flag_write_o;
    logic       reg_write_o, mem_write_o, pcs_o;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .op_i          (op_i),
        .funct_i       (funct_i),
        .rd_i          (rd_i),
        .mem_ready_i   (mem_ready_i),
        .ir_write_o    (ir_write_o),
        .next_pc_o     (next_pc_o),
        .adr_src_o     (adr_src_o),
        .alu_src_a_o   (alu_src_a_o),
        .alu_src_b_o   (alu_src_b_o),
        .result_src_o  (result_src_o),
        .alu_control_o (alu_control_o),
        .flag_write_o  (flag_write_o),
        .reg_write_o   (reg_write_o),
        .mem_write_o   (mem_write_o),
        .pcs_o         (pcs_o),
        .state_o       (state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] result;
        logic [1:0] alu;
        logic [1:0] fw;
        logic       reg_write;
        logic       mem_write;
        logic       pcs;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference behaviour of one cycle, written from the controller's output table.
    function automatic obs_t model(state_e st, logic [1:0] op, logic [5:0] funct,
                                   logic [3:0] rd, logic ready);
        obs_t o;
        logic [3:0] cmd;
        bit is_add, is_sub, is_and, is_orr, is_cmp, dp_write, nz, cv;
        logic [1:0] alu;
        o = '0;
        cmd = funct[4:1];
        is_add = (cmd == 4'b0100);
        is_sub = (cmd == 4'b0010);
        is_and = (cmd == 4'b0000);
        is_orr = (cmd == 4'b1100);
        is_cmp = (cmd == 4'b1010);
        dp_write = is_add | is_sub | is_and | is_orr;
        alu = (is_sub | is_cmp) ? 2'd1 : is_and ? 2'd2 : is_orr ? 2'd3 : 2'd0;
        nz = (dp_write & funct[0]) | is_cmp;
        cv = nz & (is_add | is_sub | is_cmp);
        o.st = st;
        case (st)
            StFetch: begin
                o.ir_write = ready; o.next_pc = ready;
                o.src_a = 1'b1; o.src_b = 2'd2; o.result = 2'd2;
            end
            StDecode: begin
                o.src_a = 1'b1; o.src_b = 2'd2; o.result = 2'd2;
            end
            StMemAdr:   o.src_b = 2'd1;
            StMemRead:  o.adr_src = 1'b1;
            StMemWb: begin
                o.result = 2'd1; o.reg_write = 1'b1; o.pcs = (rd == 4'd15);
            end
            StMemWrite: begin
                o.adr_src = 1'b1; o.mem_write = 1'b1;
            end
            StExecR: begin
                o.alu = alu; o.fw = {nz, cv};
            end
            StExecI: begin
                o.src_b = 2'd1; o.alu = alu; o.fw = {nz, cv};
            end
            StAluWb: begin
                o.reg_write = dp_write; o.pcs = dp_write && (rd == 4'd15);
            end
            StBranch: begin
                o.src_b = 2'd1; o.result = 2'd2; o.pcs = 1'b1;
            end
            default: ;
        endcase
        if (op == 2'b11 && st == StDecode) o.pcs = 1'b0;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.st = state_o;          a.ir_write = ir_write_o;   a.next_pc = next_pc_o;
        a.adr_src = adr_src_o;   a.src_a = alu_src_a_o;     a.src_b = alu_src_b_o;
        a.result = result_src_o; a.alu = alu_control_o;     a.fw = flag_write_o;
        a.reg_write = reg_write_o; a.mem_write = mem_write_o; a.pcs = pcs_o;
        return a;
    endfunction

    task automatic check_obs(string name, obs_t exp);
        obs_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s #%0d: got st=%0d ir=%b npc=%b adr=%b a=%b b=%0d res=%0d alu=%0d fw=%b rw=%b mw=%b pcs=%b, expected st=%0d ir=%b npc=%b adr=%b a=%b b=%0d res=%0d alu=%0d fw=%b rw=%b mw=%b pcs=%b",
                     name, n_checks,
                     act.st, act.ir_write, act.next_pc, act.adr_src, act.src_a, act.src_b,
                     act.result, act.alu, act.fw, act.reg_write, act.mem_write, act.pcs,
                     exp.st, exp.ir_write, exp.next_pc, exp.adr_src, exp.src_a, exp.src_b,
                     exp.result, exp.alu, exp.fw, exp.reg_write, exp.mem_write, exp.pcs);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared at the falling edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs("cycle", e);
            end
        end
    end

    // Release reset at the start of a cycle that the scoreboard expects to be FETCH.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        exp_q.push_back(model(StFetch, op_i, funct_i, rd_i, 1'b0));
    endtask

    // Expand one instruction into its state trace and drive it cycle by cycle.
    task automatic run_instr(logic [1:0] op, logic [5:0] funct, logic [3:0] rd,
                             int fwait, int mwait, bit abort_exec);
        state_e seq[$];
        bit     waiting, last;
        repeat (fwait + 1) seq.push_back(StFetch);
        seq.push_back(StDecode);
        case (op)
            2'b01: begin
                seq.push_back(StMemAdr);
                if (funct[0]) begin
                    repeat (mwait + 1) seq.push_back(StMemRead);
                    seq.push_back(StMemWb);
                end else begin
                    repeat (mwait + 1) seq.push_back(StMemWrite);
                end
            end
            2'b00: begin
                seq.push_back(funct[5] ? StExecI : StExecR);
                seq.push_back(StAluWb);
            end
            2'b10: seq.push_back(StBranch);
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clk);
            #1;
            op_i = op;
            funct_i = funct;
            rd_i = rd;
            waiting = (seq[i] == StFetch) || (seq[i] == StMemRead) || (seq[i] == StMemWrite);
            last = (i == seq.size() - 1) || (seq[i + 1] != seq[i]);
            mem_ready_i = waiting ? last : 1'($urandom_range(0, 1));
            exp_q.push_back(model(seq[i], op, funct, rd, mem_ready_i));
            if (abort_exec && seq[i] == StExecR) begin
                @(negedge clk);
                #2;
                rst_i = 1'b0;
                mem_ready_i = 1'b1;
                #1;
                check_obs("abort_async", model(StFetch, op, funct, rd, 1'b0));
                @(posedge clk);
                #1;
                check_obs("abort_hold", model(StFetch, op, funct, rd, 1'b0));
                rst_i = 1'b1;
                mem_ready_i = 1'b0;
                exp_q.push_back(model(StFetch, op, funct, rd, 1'b0));
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmds [6];
        logic [1:0] op;
        logic [3:0] cmd;
        logic [3:0] rd;
        logic       imm;
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b0111;

        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        op_i = 2'b00;
        funct_i = 6'b001000;
        rd_i = 4'd1;
        repeat (3) begin
            @(negedge clk);
            check_obs("reset", model(StFetch, 2'b00, 6'b001000, 4'd1, 1'b0));
        end
        release_reset();

        // Directed sequence: ADD, SUBS imm to R15, CMP, LDR with waits, STR, B, undefined, aborted ADD.
        run_instr(2'b00, 6'b001000, 4'd1, 0, 0, 1'b0);
        run_instr(2'b00, 6'b100101, 4'd15, 0, 0, 1'b0);
        run_instr(2'b00, 6'b010101, 4'd3, 0, 0, 1'b0);
        run_instr(2'b01, 6'b011001, 4'd4, 0, 2, 1'b0);
        run_instr(2'b01, 6'b011000, 4'd5, 1, 0, 1'b0);
        run_instr(2'b10, 6'b100000, 4'd0, 0, 0, 1'b0);
        run_instr(2'b11, 6'b000000, 4'd15, 0, 0, 1'b0);
        run_instr(2'b00, 6'b001000, 4'd2, 0, 0, 1'b1);
        run_instr(2'b01, 6'b011001, 4'd15, 0, 0, 1'b0);

        // Random instruction mix with random memory wait states.
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            cmd = cmds[$urandom_range(0, 5)];
            if (cmd == 4'b0111) cmd = 4'($urandom_range(0, 15));
            imm = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr(op, {imm, cmd, 1'($urandom_range(0, 1))}, rd,
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      (op == 2'b00) && !imm && ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
